seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment encodings, conversion FSM states and the power-of-ten helper
// for the multiplexed seven-segment display controller.
package seg_pkg;

    // Active-high patterns, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per clock, then a
// single COMMIT cycle where done is high and bcd holds the result.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_W-1:0]      bin,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] bcd
);

    localparam int CW = $clog2(DATA_W + 1);

    conv_state_t            state;
    logic [CW-1:0]          shift_cnt;
    logic [DATA_W-1:0]      bin_sr;
    logic [DIGITS-1:0][3:0] bcd_sr;
    logic [DIGITS-1:0][3:0] bcd_adj;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign bcd_adj[d] = (bcd_sr[d] >= 4'd5) ? bcd_sr[d] + 4'd3 : bcd_sr[d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_cnt <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        bin_sr    <= bin;
                        bcd_sr    <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    shift_cnt        <= shift_cnt + 1'b1;
                    if (shift_cnt == CW'(DATA_W - 1)) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd = bcd_sr;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment controller: captures a value on load, converts it
// to BCD in the background, then scans digits with blanking, sign and points.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int DATA_W      = 20,
    parameter int CNT_SEG_MAX = 49,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DIGITS-1:0] point_in,
    input  logic              sign_in,
    input  logic              load,
    input  logic              seg_en,
    output logic              busy,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);

    localparam int          CNT_W   = (CNT_SEG_MAX > 0) ? $clog2(CNT_SEG_MAX + 1) : 1;
    localparam int          IDX_W   = $clog2(DIGITS);
    localparam logic [7:0]  SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [63:0] LIM_POS = pow10(DIGITS);
    localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);

    logic                   accept;
    logic                   ovf_now;
    logic                   conv_done;
    logic [DIGITS-1:0][3:0] conv_bcd;

    logic [DIGITS-1:0]      pend_point;
    logic                   pend_sign;
    logic                   pend_ovf;

    logic [DIGITS-1:0][3:0] disp_bcd;
    logic [DIGITS-1:0]      disp_point;
    logic                   disp_sign;
    logic                   disp_ovf;

    logic [CNT_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]       dig_idx;

    logic                   lit_acc;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      minus_pos;
    logic [DIGITS-1:0][7:0] pat;

    assign accept = load & ~busy;
    // A minus sign costs one digit of range
    assign ovf_now = 64'(data_in) >= (sign_in ? LIM_NEG : LIM_POS);

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .start (accept),
        .bin   (data_in),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend_point <= '0;
            pend_sign  <= 1'b0;
            pend_ovf   <= 1'b0;
            disp_bcd   <= '0;
            disp_point <= '0;
            disp_sign  <= 1'b0;
            disp_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                pend_point <= point_in;
                pend_sign  <= sign_in;
                pend_ovf   <= ovf_now;
            end
            if (conv_done) begin
                disp_bcd   <= conv_bcd;
                disp_point <= pend_point;
                disp_sign  <= pend_sign;
                disp_ovf   <= pend_ovf;
            end
        end
    end

    // Walk down from the top digit: a digit stays blank until something at or above it is visible
    always_comb begin
        lit_acc = 1'b0;
        blank   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lit_acc  = lit_acc | (disp_bcd[k] != 4'd0) | disp_point[k];
            blank[k] = (k != 0) && !lit_acc;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_pat
        if (k == 0) begin : g_lsd
            assign minus_pos[k] = 1'b0;
        end else begin : g_hi
            assign minus_pos[k] = blank[k] & ~blank[k-1];
        end

        assign pat[k] = disp_ovf  ? SEG_MINUS :
                        blank[k]  ? ((disp_sign & minus_pos[k]) ? SEG_MINUS : SEG_BLANK) :
                                    (seg_digit(disp_bcd[k]) | (disp_point[k] ? SEG_DP : SEG_BLANK));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == CNT_W'(CNT_SEG_MAX)) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // sel and seg share one register stage so the digit and its pattern switch together
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sel <= '0;
            seg <= SEG_OFF;
        end else if (!seg_en) begin
            sel <= '0;
            seg <= SEG_OFF;
        end else begin
            sel <= DIGITS'(1) << dig_idx;
            seg <= (SEG_ACT_LOW != 0) ? ~pat[dig_idx] : pat[dig_idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=6, DATA_W=20, CNT_SEG_MAX=3.
module tb_seg_scan_ctrl;

    localparam int DIGITS      = 6;
    localparam int DATA_W      = 20;
    localparam int CNT_SEG_MAX = 3;
    localparam int DWELL       = CNT_SEG_MAX + 1;
    localparam int SCAN_LEN    = DIGITS * DWELL;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic [DIGITS-1:0] point_in = '0;
    logic              sign_in = 1'b0;
    logic              load = 1'b0;
    logic              seg_en = 1'b1;
    logic              busy;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;

    int n_cmp = 0;
    int n_bad = 0;
    int ecount;
    int sel_err;
    logic [7:0] obs [DIGITS];

    seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .DATA_W      (DATA_W),
        .CNT_SEG_MAX (CNT_SEG_MAX),
        .SEG_ACT_LOW (1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .data_in  (data_in),
        .point_in (point_in),
        .sign_in  (sign_in),
        .load     (load),
        .seg_en   (seg_en),
        .busy     (busy),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 sys_clk = ~sys_clk;

    // Clock edges since reset release; the scan position follows from this alone
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) ecount <= 0;
        else         ecount <= ecount + 1;
    end

    function automatic int scan_idx(input int ec);
        return ((ec - 1) / DWELL) % DIGITS;
    endfunction

    task automatic collect_scan;
        int idx;
        logic [DIGITS-1:0] exp_sel;
        sel_err = 0;
        for (int i = 0; i < SCAN_LEN; i++) begin
            @(negedge sys_clk);
            idx = scan_idx(ecount);
            exp_sel = '0;
            exp_sel[idx] = 1'b1;
            if (sel !== exp_sel) sel_err++;
            obs[idx] = seg;
        end
    endtask

    task automatic do_load(input logic [DATA_W-1:0] v, input logic [DIGITS-1:0] p, input logic s);
        data_in  = v;
        point_in = p;
        sign_in  = s;
        load     = 1'b1;
        @(negedge sys_clk);
        load     = 1'b0;
    endtask

    task automatic count_busy(output int nb);
        nb = 0;
        while (busy === 1'b1 && nb < 60) begin
            nb++;
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (sel !== 6'b0) begin n_bad++; $display("FAIL rst_sel got %b want 000000", sel); end
        n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL rst_seg got %h want ff", seg); end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        collect_scan();
        n_cmp++; if (sel_err !== 0) begin n_bad++; $display("FAIL rst_scan_sel errors %0d want 0", sel_err); end
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL rst_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    task automatic test_convert;
        int nb;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        do_load(20'd123456, 6'b000000, 1'b0);
        count_busy(nb);
        n_cmp++; if (nb !== 21) begin n_bad++; $display("FAIL conv_busy_len got %0d want 21", nb); end
        repeat (2) @(negedge sys_clk);
        collect_scan();
        n_cmp++; if (sel_err !== 0) begin n_bad++; $display("FAIL conv_scan_sel errors %0d want 0", sel_err); end
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL conv_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    task automatic test_sign_point;
        int nb;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'hA4, 8'h99, 8'h40, 8'hBF, 8'hFF, 8'hFF};
        do_load(20'd42, 6'b000100, 1'b1);
        count_busy(nb);
        n_cmp++; if (nb !== 21) begin n_bad++; $display("FAIL sp_busy_len got %0d want 21", nb); end
        repeat (2) @(negedge sys_clk);
        collect_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL sp_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    task automatic test_overflow;
        int nb;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        do_load(20'd100000, 6'b001000, 1'b1);
        count_busy(nb);
        repeat (2) @(negedge sys_clk);
        collect_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL ovf_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
        exp_d = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hBF};
        do_load(20'd99999, 6'b000000, 1'b1);
        count_busy(nb);
        repeat (2) @(negedge sys_clk);
        collect_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL max_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int nb;
        int hi_after;
        int idx;
        logic [7:0] old_d [DIGITS];
        logic [7:0] exp_d [DIGITS];
        old_d = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hBF};
        exp_d = '{8'hF8, 8'hF8, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
        do_load(20'd777, 6'b000000, 1'b0);
        nb = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                load = 1'b1; data_in = 20'd555; sign_in = 1'b1; point_in = 6'b111111;
            end else begin
                load = 1'b0;
            end
            if (c == 10) begin
                idx = scan_idx(ecount);
                n_cmp++;
                if (seg !== old_d[idx]) begin n_bad++; $display("FAIL b2b_old_shown digit%0d got %h want %h", idx, seg, old_d[idx]); end
            end
            if (busy !== 1'b1) break;
            nb++;
            @(negedge sys_clk);
        end
        load = 1'b0;
        n_cmp++; if (nb !== 21) begin n_bad++; $display("FAIL b2b_busy_len got %0d want 21", nb); end
        hi_after = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy !== 1'b0) hi_after++;
            @(negedge sys_clk);
        end
        n_cmp++; if (hi_after !== 0) begin n_bad++; $display("FAIL b2b_busy_after got %0d high cycles want 0", hi_after); end
        collect_scan();
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL b2b_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    task automatic test_blank_enable;
        int idx;
        logic [DIGITS-1:0] exp_sel;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'hF8, 8'hF8, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
        repeat (3) @(negedge sys_clk);
        seg_en = 1'b0;
        @(negedge sys_clk);
        n_cmp++; if (sel !== 6'b0) begin n_bad++; $display("FAIL dis_sel got %b want 000000", sel); end
        n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL dis_seg got %h want ff", seg); end
        repeat (6) @(negedge sys_clk);
        n_cmp++; if (sel !== 6'b0 || seg !== 8'hFF) begin n_bad++; $display("FAIL dis_hold got %b/%h want 000000/ff", sel, seg); end
        seg_en = 1'b1;
        @(negedge sys_clk);
        idx = scan_idx(ecount);
        exp_sel = '0;
        exp_sel[idx] = 1'b1;
        n_cmp++; if (sel !== exp_sel) begin n_bad++; $display("FAIL reen_sel got %b want %b", sel, exp_sel); end
        n_cmp++; if (seg !== exp_d[idx]) begin n_bad++; $display("FAIL reen_seg got %h want %h", seg, exp_d[idx]); end
    endtask

    task automatic test_reset_mid;
        int hi;
        logic [7:0] exp_d [DIGITS];
        exp_d = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(20'd31415, 6'b000010, 1'b1);
        repeat (9) @(negedge sys_clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", busy); end
        sys_rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_cmp++; if (sel !== 6'b0 || seg !== 8'hFF) begin n_bad++; $display("FAIL mid_rst_out got %b/%h want 000000/ff", sel, seg); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            if (busy !== 1'b0) hi++;
        end
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL mid_busy_after got %0d high cycles want 0", hi); end
        collect_scan();
        n_cmp++; if (sel_err !== 0) begin n_bad++; $display("FAIL mid_scan_sel errors %0d want 0", sel_err); end
        for (int k = 0; k < DIGITS; k++) begin
            n_cmp++;
            if (obs[k] !== exp_d[k]) begin n_bad++; $display("FAIL mid_digit%0d got %h want %h", k, obs[k], exp_d[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_sign_point();
        test_overflow();
        test_back_to_back();
        test_blank_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
